// File: rtl/vit_pkg.sv
// Shared Viterbi constants and saturating metric arithmetic used by the ACS datapath.
package vit_pkg;
  localparam int WIDTH_BM = 9;
  localparam int K        = 7;
  localparam int N        = 2 ** (K - 1);
  localparam int INIT_LOW = -128;

  typedef logic signed [WIDTH_BM-1:0] metric_t;

  // Clamp x into the signed range of a w-bit metric.
  function automatic int sat_metric(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction
endpackage

// File: rtl/acs_butterfly.sv
// One radix-2 add-compare-select butterfly; ties resolve to the cand0 path.
module acs_butterfly
  import vit_pkg::*;
#(
  parameter int W      = WIDTH_BM,
  parameter int THRESH = 2 ** (WIDTH_BM - 2)
) (
  input  logic [W-1:0] pm_a_i,
  input  logic [W-1:0] pm_b_i,
  input  logic [W-1:0] bm_i,
  input  logic         norm_i,
  output logic [W-1:0] pm_lo_o,
  output logic [W-1:0] pm_hi_o,
  output logic         dec_lo_o,
  output logic         dec_hi_o
);
  int a, b, bm, lo0, lo1, hi0, hi1;

  always_comb begin
    a  = int'($signed(pm_a_i));
    b  = int'($signed(pm_b_i));
    bm = int'($signed(bm_i));
    if (norm_i) begin
      a = sat_metric(a - THRESH, W);
      b = sat_metric(b - THRESH, W);
    end
    lo0      = sat_metric(a + bm, W);
    lo1      = sat_metric(b - bm, W);
    hi0      = sat_metric(a - bm, W);
    hi1      = sat_metric(b + bm, W);
    dec_lo_o = (lo1 > lo0);
    dec_hi_o = (hi1 > hi0);
    pm_lo_o  = W'(dec_lo_o ? lo1 : lo0);
    pm_hi_o  = W'(dec_hi_o ? hi1 : hi0);
  end
endmodule

// File: rtl/acs_array.sv
// Add-compare-select array: ping-pong path-metric banks, P butterflies per beat,
// per-step survivor vector and best-state tracking with automatic renormalisation.
//   state   | meaning
//   ST_IDLE | not accepting branch metrics
//   ST_RUN  | accepting one butterfly group per valid beat
module acs_array #(
  parameter int  WIDTH_BM    = vit_pkg::WIDTH_BM,
  parameter int  K           = vit_pkg::K,
  parameter int  P           = 8,
  parameter int  INIT_LOW    = vit_pkg::INIT_LOW,
  parameter int  NORM_THRESH = 2 ** (WIDTH_BM - 2),
  localparam int N           = 2 ** (K - 1),
  localparam int G           = N / (2 * P),
  localparam int GW          = (G > 1) ? $clog2(G) : 1,
  localparam int SW          = K - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_sync_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic                  tail_biting_en_i,
  input  logic [P*WIDTH_BM-1:0] bm_i,
  input  logic                  bm_valid_i,
  output logic                  bm_ready_o,
  output logic [GW-1:0]         bfly_idx_o,
  output logic [N-1:0]          dec_o,
  output logic                  dec_valid_o,
  output logic [SW-1:0]         best_state_o,
  output logic [WIDTH_BM-1:0]   best_pm_o
);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                       state_q, state_d;
  logic [GW-1:0]              grp_q, grp_d;
  logic                       rd_sel_q;
  logic                       norm_q;
  logic [WIDTH_BM-1:0]        bank_q [2][N];
  logic [N-1:0]               dec_acc_q, dec_q, dec_step;
  logic                       dec_valid_q;
  logic [SW-1:0]              best_state_q, run_state_q, step_state;
  logic signed [WIDTH_BM-1:0] best_pm_q, run_pm_q, step_pm;
  logic                       beat, grp_last;

  logic [SW-1:0]       lo_idx [P];
  logic [SW-1:0]       hi_idx [P];
  logic [WIDTH_BM-1:0] new_lo [P];
  logic [WIDTH_BM-1:0] new_hi [P];
  logic                dec_lo [P];
  logic                dec_hi [P];

  assign beat     = en_i && !start_i && (state_q == ST_RUN) && bm_valid_i;
  assign grp_last = (int'(grp_q) == G - 1);

  for (genvar j = 0; j < P; j++) begin : g_lane
    logic [SW-1:0] a_idx;
    assign lo_idx[j] = SW'(int'(grp_q) * P + j);
    assign hi_idx[j] = SW'(int'(grp_q) * P + j + N / 2);
    assign a_idx     = SW'(2 * (int'(grp_q) * P + j));

    acs_butterfly #(.W(WIDTH_BM), .THRESH(NORM_THRESH)) u_bfly (
      .pm_a_i  (bank_q[rd_sel_q][a_idx]),
      .pm_b_i  (bank_q[rd_sel_q][a_idx | SW'(1)]),
      .bm_i    (bm_i[j*WIDTH_BM +: WIDTH_BM]),
      .norm_i  (norm_q),
      .pm_lo_o (new_lo[j]),
      .pm_hi_o (new_hi[j]),
      .dec_lo_o(dec_lo[j]),
      .dec_hi_o(dec_hi[j])
    );
  end

  // New-state indices are not monotonic across groups, so ties compare indices explicitly.
  always_comb begin
    step_pm    = $signed(new_lo[0]);
    step_state = lo_idx[0];
    dec_step   = dec_acc_q;
    for (int j = 0; j < P; j++) begin
      dec_step[lo_idx[j]] = dec_lo[j];
      dec_step[hi_idx[j]] = dec_hi[j];
      if ($signed(new_lo[j]) > step_pm ||
          ($signed(new_lo[j]) == step_pm && lo_idx[j] < step_state)) begin
        step_pm    = $signed(new_lo[j]);
        step_state = lo_idx[j];
      end
      if ($signed(new_hi[j]) > step_pm ||
          ($signed(new_hi[j]) == step_pm && hi_idx[j] < step_state)) begin
        step_pm    = $signed(new_hi[j]);
        step_state = hi_idx[j];
      end
    end
    if (grp_q != '0 && (run_pm_q > step_pm ||
                        (run_pm_q == step_pm && run_state_q < step_state))) begin
      step_pm    = run_pm_q;
      step_state = run_state_q;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    if (!en_i) begin
      state_d = ST_IDLE;
      grp_d   = '0;
    end else if (start_i) begin
      state_d = ST_RUN;
      grp_d   = '0;
    end else if (beat) begin
      grp_d = grp_last ? '0 : grp_q + GW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state_q      <= ST_IDLE;
      grp_q        <= '0;
      rd_sel_q     <= 1'b0;
      norm_q       <= 1'b0;
      dec_acc_q    <= '0;
      dec_q        <= '0;
      dec_valid_q  <= 1'b0;
      best_state_q <= '0;
      best_pm_q    <= '0;
      run_state_q  <= '0;
      run_pm_q     <= '0;
      for (int s = 0; s < N; s++) begin
        bank_q[0][s] <= '0;
        bank_q[1][s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      dec_valid_q <= 1'b0;
      if (!en_i) begin
        dec_q        <= '0;
        best_state_q <= '0;
        best_pm_q    <= '0;
      end else if (start_i) begin
        norm_q <= 1'b0;
        for (int s = 0; s < N; s++)
          bank_q[rd_sel_q][s] <= (tail_biting_en_i || s == 0) ? '0 : WIDTH_BM'(INIT_LOW);
      end else if (beat) begin
        dec_acc_q   <= dec_step;
        run_pm_q    <= step_pm;
        run_state_q <= step_state;
        for (int j = 0; j < P; j++) begin
          bank_q[~rd_sel_q][lo_idx[j]] <= new_lo[j];
          bank_q[~rd_sel_q][hi_idx[j]] <= new_hi[j];
        end
        if (grp_last) begin
          rd_sel_q     <= ~rd_sel_q;
          dec_q        <= dec_step;
          dec_valid_q  <= 1'b1;
          best_state_q <= step_state;
          best_pm_q    <= step_pm;
          norm_q       <= (int'(step_pm) >= NORM_THRESH);
        end
      end
    end
  end

  assign bm_ready_o   = (state_q == ST_RUN);
  assign bfly_idx_o   = grp_q;
  assign dec_o        = dec_q;
  assign dec_valid_o  = dec_valid_q;
  assign best_state_o = best_state_q;
  assign best_pm_o    = best_pm_q;
endmodule

// File: tb/tb_acs_array.sv
// Scoreboard bench for acs_array: four parameterisations share the control inputs,
// a reference trellis model predicts each step and the selected instance is checked.
module tb_acs_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b1, start = 1'b0, tbe = 1'b0, bm_valid = 1'b0;
  logic [71:0] bm_bus = '0;

  logic              ready0, dv0, ready1, dv1, ready2, dv2, ready3, dv3;
  logic [0:0]        idx0, idx1, idx2;
  logic [1:0]        idx3;
  logic [3:0]        dec0, dec1, dec2;
  logic [63:0]       dec3;
  logic [1:0]        bs0, bs1, bs2;
  logic [5:0]        bs3;
  logic signed [8:0] pm0, pm1, pm2, pm3;

  acs_array #(.K(3), .P(1)) u0 (
    .clk_i(clk), .rst_sync_i(rst), .en_i(en), .start_i(start), .tail_biting_en_i(tbe),
    .bm_i(bm_bus[8:0]), .bm_valid_i(bm_valid), .bm_ready_o(ready0), .bfly_idx_o(idx0),
    .dec_o(dec0), .dec_valid_o(dv0), .best_state_o(bs0), .best_pm_o(pm0));
  acs_array #(.K(3), .P(2), .NORM_THRESH(64)) u1 (
    .clk_i(clk), .rst_sync_i(rst), .en_i(en), .start_i(start), .tail_biting_en_i(tbe),
    .bm_i(bm_bus[17:0]), .bm_valid_i(bm_valid), .bm_ready_o(ready1), .bfly_idx_o(idx1),
    .dec_o(dec1), .dec_valid_o(dv1), .best_state_o(bs1), .best_pm_o(pm1));
  acs_array #(.K(3), .P(1), .INIT_LOW(-250)) u2 (
    .clk_i(clk), .rst_sync_i(rst), .en_i(en), .start_i(start), .tail_biting_en_i(tbe),
    .bm_i(bm_bus[8:0]), .bm_valid_i(bm_valid), .bm_ready_o(ready2), .bfly_idx_o(idx2),
    .dec_o(dec2), .dec_valid_o(dv2), .best_state_o(bs2), .best_pm_o(pm2));
  acs_array u3 (
    .clk_i(clk), .rst_sync_i(rst), .en_i(en), .start_i(start), .tail_biting_en_i(tbe),
    .bm_i(bm_bus), .bm_valid_i(bm_valid), .bm_ready_o(ready3), .bfly_idx_o(idx3),
    .dec_o(dec3), .dec_valid_o(dv3), .best_state_o(bs3), .best_pm_o(pm3));

  int          sel = 0;
  int          n_tests = 0, n_fail = 0;
  logic        mon_ready, mon_dv;
  int          mon_idx, mon_st, mon_pm;
  logic [63:0] mon_dec;

  always_comb begin
    mon_ready = ready0; mon_dv = dv0; mon_idx = int'(idx0);
    mon_st = int'(bs0); mon_pm = int'(pm0); mon_dec = 64'(dec0);
    case (sel)
      1: begin mon_ready = ready1; mon_dv = dv1; mon_idx = int'(idx1);
               mon_st = int'(bs1); mon_pm = int'(pm1); mon_dec = 64'(dec1); end
      2: begin mon_ready = ready2; mon_dv = dv2; mon_idx = int'(idx2);
               mon_st = int'(bs2); mon_pm = int'(pm2); mon_dec = 64'(dec2); end
      3: begin mon_ready = ready3; mon_dv = dv3; mon_idx = int'(idx3);
               mon_st = int'(bs3); mon_pm = int'(pm3); mon_dec = dec3; end
      default: ;
    endcase
  end

  function automatic int dut_n(input int s);   return (s == 3) ? 64 : 4; endfunction
  function automatic int dut_p(input int s);   return (s == 3) ? 8 : ((s == 1) ? 2 : 1); endfunction
  function automatic int dut_thr(input int s); return (s == 1) ? 64 : 128; endfunction
  function automatic int dut_low(input int s); return (s == 2) ? -250 : -128; endfunction

  typedef struct { logic [63:0] dec; int st; int pm; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   mpm[64];
  bit   mnorm;

  function automatic int sat9(input int x);
    return (x > 255) ? 255 : ((x < -256) ? -256 : x);
  endfunction

  task automatic model_init(input bit tbv, input int low);
    for (int s = 0; s < 64; s++) mpm[s] = (tbv || s == 0) ? 0 : low;
    mnorm = 1'b0;
  endtask

  task automatic model_step(input int n, input int thr, input int bmv[32]);
    int np[64];
    int a, b, c0, c1;
    exp_t e;
    e.dec = '0;
    for (int i = 0; i < n / 2; i++) begin
      a = mnorm ? sat9(mpm[2*i] - thr) : mpm[2*i];
      b = mnorm ? sat9(mpm[2*i+1] - thr) : mpm[2*i+1];
      c0 = sat9(a + bmv[i]); c1 = sat9(b - bmv[i]);
      np[i] = (c1 > c0) ? c1 : c0; e.dec[i] = (c1 > c0);
      c0 = sat9(a - bmv[i]); c1 = sat9(b + bmv[i]);
      np[i+n/2] = (c1 > c0) ? c1 : c0; e.dec[i+n/2] = (c1 > c0);
    end
    e.st = 0; e.pm = np[0];
    for (int s = 1; s < n; s++) if (np[s] > e.pm) begin e.pm = np[s]; e.st = s; end
    for (int s = 0; s < n; s++) mpm[s] = np[s];
    mnorm = (e.pm >= thr);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_dv === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL dec_valid_unexpected sel=%0d got pulse, expected none", sel);
      end else begin
        mon_e = sb.pop_front();
        if (mon_dec !== mon_e.dec || mon_st !== mon_e.st || mon_pm !== mon_e.pm) begin
          n_fail++;
          $display("FAIL step_result sel=%0d got dec=%h st=%0d pm=%0d expected dec=%h st=%0d pm=%0d",
                   sel, mon_dec, mon_st, mon_pm, mon_e.dec, mon_e.st, mon_e.pm);
        end
      end
    end
  end

  task automatic do_start(input int s, input bit tbv);
    @(negedge clk);
    sel = s; start = 1'b1; tbe = tbv; bm_valid = 1'b0;
    model_init(tbv, dut_low(s));
    @(negedge clk);
    start = 1'b0; tbe = 1'b0;
  endtask

  task automatic run_step(input int s, input int bmv[32], input int gap);
    int          p, gcnt;
    logic [71:0] bus;
    p = dut_p(s);
    gcnt = dut_n(s) / (2 * p);
    model_step(dut_n(s), dut_thr(s), bmv);
    for (int g = 0; g < gcnt; g++) begin
      bus = '0;
      for (int j = 0; j < p; j++) bus[j*9 +: 9] = 9'(bmv[g*p+j]);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        bm_valid = 1'b0; bm_bus = '1;
        n_tests++;
        if (mon_idx !== g) begin
          n_fail++; $display("FAIL gap_bfly_idx got %0d expected %0d", mon_idx, g);
        end
      end
      @(negedge clk);
      bm_bus = bus; bm_valid = 1'b1;
      n_tests++;
      if (mon_idx !== g || mon_ready !== 1'b1) begin
        n_fail++; $display("FAIL beat_bfly_idx got idx=%0d ready=%b expected idx=%0d ready=1", mon_idx, mon_ready, g);
      end
    end
  endtask

  task automatic stop_beats();
    @(negedge clk);
    bm_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s_missing_dec_valid got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (mon_ready !== 1'b0 || mon_idx !== 0 || mon_dec !== '0 || mon_dv !== 1'b0 ||
        mon_st !== 0 || mon_pm !== 0) begin
      n_fail++;
      $display("FAIL %s got ready=%b idx=%0d dec=%h dv=%b st=%0d pm=%0d expected all zero",
               name, mon_ready, mon_idx, mon_dec, mon_dv, mon_st, mon_pm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; bm_valid = 1'b0;
    repeat (3) @(negedge clk);
    sel = 0; #1; check_idle_outputs("reset_k3");
    sel = 3; #1; check_idle_outputs("reset_k7");
    @(negedge clk);
    rst = 1'b0; sel = 0;
  endtask

  task automatic test_zero_state();
    int bmv[32];
    do_start(0, 1'b0);
    n_tests++;
    if (mon_ready !== 1'b1 || mon_idx !== 0) begin
      n_fail++; $display("FAIL start_run got ready=%b idx=%0d expected 1 0", mon_ready, mon_idx);
    end
    bmv = '{default: 0}; bmv[0] = 5; bmv[1] = 3;
    run_step(0, bmv, 0);
    n_tests++;
    if (mon_dv !== 1'b0) begin n_fail++; $display("FAIL latency_early got dv=%b expected 0", mon_dv); end
    @(negedge clk);
    bm_valid = 1'b0;
    n_tests++;
    if (mon_dv !== 1'b1) begin n_fail++; $display("FAIL latency got dv=%b expected 1", mon_dv); end
    @(negedge clk);
    n_tests++;
    if (mon_dv !== 1'b0 || mon_dec !== 64'h8 || mon_st !== 0 || mon_pm !== 5) begin
      n_fail++;
      $display("FAIL zero_state_hold got dv=%b dec=%h st=%0d pm=%0d expected dv=0 dec=8 st=0 pm=5",
               mon_dv, mon_dec, mon_st, mon_pm);
    end
    bmv[0] = 0; bmv[1] = 0;
    run_step(0, bmv, 0);
    stop_beats();
    drain("zero_state");
  endtask

  task automatic test_tail_biting();
    int bmv[32];
    bmv = '{default: 0};
    do_start(0, 1'b1);
    run_step(0, bmv, 0);
    stop_beats();
    drain("tail_biting");
    n_tests++;
    if (mon_dec !== '0 || mon_st !== 0 || mon_pm !== 0) begin
      n_fail++; $display("FAIL tail_biting_ties got dec=%h st=%0d pm=%0d expected 0 0 0", mon_dec, mon_st, mon_pm);
    end
  endtask

  task automatic test_renorm();
    int bmv[32];
    bmv = '{default: 0}; bmv[0] = 20; bmv[1] = 20;
    do_start(1, 1'b1);
    for (int s = 0; s < 6; s++) run_step(1, bmv, 0);
    stop_beats();
    drain("renorm");
    n_tests++;
    if (mon_pm !== 56) begin n_fail++; $display("FAIL renorm_final got pm=%0d expected 56", mon_pm); end
  endtask

  task automatic test_saturation();
    int bmv[32];
    bmv = '{default: 0}; bmv[0] = 20; bmv[1] = 20;
    do_start(2, 1'b0);
    run_step(2, bmv, 0);
    stop_beats();
    drain("saturation");
    n_tests++;
    if (mon_dec !== 64'h8 || mon_st !== 0 || mon_pm !== 20) begin
      n_fail++; $display("FAIL saturation_clamp got dec=%h st=%0d pm=%0d expected 8 0 20", mon_dec, mon_st, mon_pm);
    end
    run_step(2, bmv, 0);
    stop_beats();
    drain("saturation2");
  endtask

  task automatic test_gaps();
    int bmv[32];
    do_start(0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      bmv = '{default: 0};
      for (int i = 0; i < 2; i++) bmv[i] = int'($urandom_range(0, 80)) - 40;
      run_step(0, bmv, 2);
    end
    stop_beats();
    drain("gaps");
  endtask

  task automatic test_wide();
    int bmv[32];
    do_start(3, 1'b0);
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 32; i++) bmv[i] = int'($urandom_range(0, 120)) - 60;
      run_step(3, bmv, 0);
    end
    stop_beats();
    drain("wide_zero");
    do_start(3, 1'b1);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) bmv[i] = int'($urandom_range(0, 120)) - 60;
      run_step(3, bmv, 1);
    end
    stop_beats();
    drain("wide_tail");
  endtask

  task automatic test_abort_start();
    int bmv[32];
    do_start(0, 1'b0);
    @(negedge clk); bm_bus = 72'd5; bm_valid = 1'b1;
    @(negedge clk); bm_bus = 72'd3; start = 1'b1;
    model_init(1'b0, -128);
    @(negedge clk); start = 1'b0; bm_valid = 1'b0;
    n_tests++;
    if (mon_idx !== 0 || mon_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_start_idx got idx=%0d ready=%b expected 0 1", mon_idx, mon_ready);
    end
    repeat (3) @(negedge clk);
    bmv = '{default: 0}; bmv[0] = 7; bmv[1] = -2;
    run_step(0, bmv, 0);
    stop_beats();
    drain("abort_start");
  endtask

  task automatic test_abort_en();
    int bmv[32];
    bmv = '{default: 0}; bmv[0] = 5; bmv[1] = 3;
    do_start(0, 1'b0);
    run_step(0, bmv, 0);
    stop_beats();
    drain("pre_en");
    @(negedge clk); bm_bus = 72'd4; bm_valid = 1'b1;
    @(negedge clk); en = 1'b0; bm_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_en_idle");
    en = 1'b1;
    repeat (3) @(negedge clk);
    do_start(0, 1'b0);
    run_step(0, bmv, 0);
    stop_beats();
    drain("abort_en");
  endtask

  task automatic test_abort_rst();
    int bmv[32];
    bmv = '{default: 0}; bmv[0] = -9; bmv[1] = 12;
    do_start(0, 1'b0);
    run_step(0, bmv, 0);
    stop_beats();
    drain("pre_rst");
    @(negedge clk); bm_bus = 72'd6; bm_valid = 1'b1;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0; bm_valid = 1'b0;
    check_idle_outputs("abort_rst_idle");
    repeat (3) @(negedge clk);
    do_start(0, 1'b1);
    run_step(0, bmv, 0);
    stop_beats();
    drain("abort_rst");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_state();
    test_tail_biting();
    test_renorm();
    test_saturation();
    test_gaps();
    test_wide();
    test_abort_start();
    test_abort_en();
    test_abort_rst();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
